// File: rtl/lf_add_seq.sv
// Round-robin arbitrated wide adder that reuses one 4-bit Ladner-Fischer slice,
// one slice per cycle from the LSB, with the carry rippled through a register.

module lf4_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [3:0] g, p;
  logic       g10, p10, g32, p32, g20, p20, g30, p30;
  logic [4:0] c;

  assign g   = a_i & b_i;
  assign p   = a_i ^ b_i;
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  // Second level: the lower-half group (1:0) fans out to both upper positions.
  assign g20 = g[2] | (p[2] & g10);
  assign p20 = p[2] & p10;
  assign g30 = g32 | (p32 & g10);
  assign p30 = p32 & p10;

  assign c[0]   = cin_i;
  assign c[1]   = g[0] | (p[0] & cin_i);
  assign c[2]   = g10  | (p10  & cin_i);
  assign c[3]   = g20  | (p20  & cin_i);
  assign c[4]   = g30  | (p30  & cin_i);
  assign sum_o  = p ^ c[3:0];
  assign cout_o = c[4];
endmodule

module lf_add_seq #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ-1:0]          req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy
);
  localparam int SLICE = 4;
  localparam int NSTEP = WIDTH / SLICE;
  localparam int IW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int IDW   = $clog2(NREQ);

  if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_width
    $error("lf_add_seq: WIDTH must be a non-zero multiple of 4");
  end
  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("lf_add_seq: NREQ must be 2..4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_nx, id_q, gnt_idx, gnt_off;
  logic [IDW:0]     gnt_sum;
  logic [2*NREQ-1:0] vrot;
  logic             gnt_any, accept, last;
  logic [NREQ-1:0]  gnt_oh;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sel_a, sel_b;
  logic             sel_cin, carry_q, cout_q;
  logic [IW-1:0]    idx_q;
  logic [SLICE-1:0] s_sum;
  logic             s_cout;

  // Rotate valids so bit 0 is the pointer position; the lowest set bit wins.
  always_comb begin
    vrot    = {req_valid, req_valid} >> ptr_q;
    gnt_any = 1'b0;
    gnt_off = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (vrot[k]) begin
        gnt_any = 1'b1;
        gnt_off = IDW'(k);
      end
    end
    gnt_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
    gnt_idx = (gnt_sum >= (IDW+1)'(NREQ)) ? IDW'(gnt_sum - (IDW+1)'(NREQ)) : IDW'(gnt_sum);
    gnt_oh  = NREQ'(1) << gnt_idx;
    ptr_nx  = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_cin = req_cin[i];
      end
    end
  end

  assign last = (idx_q == IW'(NSTEP-1));

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && gnt_any) begin
          req_ready = gnt_oh;
          accept    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN:     if (last) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands shift right so the slice always sees the next unprocessed nibble.
  lf4_slice u_slice (
    .a_i    (a_q[SLICE-1:0]),
    .b_i    (b_q[SLICE-1:0]),
    .cin_i  (carry_q),
    .sum_o  (s_sum),
    .cout_o (s_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= sel_a;
        b_q     <= sel_b;
        carry_q <= sel_cin;
        id_q    <= gnt_idx;
        idx_q   <= '0;
        ptr_q   <= ptr_nx;
      end
      if (state_q == RUN) begin
        for (int s = 0; s < NSTEP; s++) begin
          if (idx_q == IW'(s)) sum_q[s*SLICE +: SLICE] <= s_sum;
        end
        carry_q <= s_cout;
        idx_q   <= idx_q + IW'(1);
        a_q     <= a_q >> SLICE;
        b_q     <= b_q >> SLICE;
        if (last) cout_q <= s_cout;
      end
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
endmodule

// File: tb/tb_lf_add_seq.sv
// Bench for lf_add_seq: directed cases with literal results, then random traffic
// checked every cycle against a transaction-level round-robin/adder model.
module tb_lf_add_seq;
  localparam int WIDTH = 16;
  localparam int NREQ  = 2;
  localparam int NSTEP = WIDTH / 4;
  localparam int NOPS  = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NREQ-1:0]         req_valid, req_ready, req_cin;
  logic [NREQ*WIDTH-1:0]   req_a, req_b;
  logic                    rsp_valid, rsp_ready, rsp_cout, busy;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [WIDTH-1:0]        rsp_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lf_add_seq #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Model: phase 0 idle, 1 computing, 2 holding a result.
  int               m_ph = 0, m_cnt = 0, m_ptr = 0, n_rsp = 0;
  logic [WIDTH-1:0] m_sum;
  logic             m_cout;
  int               m_id;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    logic [WIDTH:0]  t;
    int              g;
    if (!rst_n) begin
      chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy}, 64'd0);
      m_ph  = 0;
      m_ptr = 0;
    end else begin
      g       = rr_pick(req_valid, m_ptr);
      exp_rdy = '0;
      if (m_ph == 0 && g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, m_ph != 0);
      chk("rsp_valid", rsp_valid, m_ph == 2);
      if (m_ph == 2) begin
        chk("rsp_sum", rsp_sum, m_sum);
        chk("rsp_cout", rsp_cout, m_cout);
        chk("rsp_id", rsp_id, m_id);
      end
      case (m_ph)
        0: if (g >= 0) begin
          t = {1'b0, req_a[g*WIDTH +: WIDTH]} + {1'b0, req_b[g*WIDTH +: WIDTH]}
              + (WIDTH+1)'(req_cin[g]);
          m_sum  = t[WIDTH-1:0];
          m_cout = t[WIDTH];
          m_id   = g;
          m_ptr  = (g + 1) % NREQ;
          m_cnt  = 0;
          m_ph   = 1;
        end
        1: begin
          m_cnt++;
          if (m_cnt == NSTEP) m_ph = 2;
        end
        default: if (rsp_ready) begin
          m_ph = 0;
          n_rsp++;
        end
      endcase
    end
  end

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]              = cin;
  endtask

  // Returns just after the accepting edge with the requester's valid dropped.
  task automatic wait_accept(input int i);
    bit ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) begin
        ok = 1;
        break;
      end
    end
    chk($sformatf("accept_req%0d", i), ok, 1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output logic [WIDTH-1:0] s, output logic c, output int id);
    bit ok = 0;
    s = '0; c = 1'b0; id = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1;
        s  = rsp_sum;
        c  = rsp_cout;
        id = int'(rsp_id);
        break;
      end
    end
    chk("rsp_seen", ok, 1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    logic [WIDTH-1:0] s;
    logic             c;
    int               id;
    logic [NREQ-1:0]  granted;
    int               n0;
    bit               done_ok;

    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Simultaneous requests straight out of reset: req0 first, then req1, twice.
    rsp_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      set_op(0, 16'h1111, 16'h2222, 1'b0);
      set_op(1, 16'hAAAA, 16'h5555, 1'b1);
      req_valid = 2'b11;
      wait_accept(0);
      wait_rsp(s, c, id);
      chk("t3_first_id", id, 0);
      chk("t3_first_sum", s, 16'h3333);
      wait_accept(1);
      wait_rsp(s, c, id);
      chk("t3_second_id", id, 1);
      chk("t3_second_sum", s, 16'h0000);
      chk("t3_second_cout", c, 1);
    end

    // Full carry ripple; response appears on the 4th edge after accept.
    rsp_ready = 1'b0;
    set_op(0, 16'hFFFF, 16'h0001, 1'b0);
    req_valid[0] = 1'b1;
    wait_accept(0);
    for (int k = 1; k <= NSTEP; k++) begin
      @(posedge clk);
      #1 chk("t1_latency", rsp_valid, k == NSTEP);
    end
    chk("t1_sum", rsp_sum, 16'h0000);
    chk("t1_cout", rsp_cout, 1);
    chk("t1_id", rsp_id, 0);

    // Stall in DONE with another requester waiting.
    set_op(1, 16'h1234, 16'h4321, 1'b1);
    req_valid[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("t4_valid", rsp_valid, 1);
      chk("t4_sum", rsp_sum, 16'h0000);
      chk("t4_id", rsp_id, 0);
      chk("t4_req_ready", req_ready, 2'b00);
      chk("t4_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    wait_accept(1);
    wait_rsp(s, c, id);
    chk("t2_sum", s, 16'h5556);
    chk("t2_cout", c, 0);
    chk("t2_id", id, 1);

    // Reset in the second RUN cycle aborts the op.
    set_op(0, 16'h1234, 16'h1111, 1'b0);
    req_valid[0] = 1'b1;
    wait_accept(0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("t5_async_reset", {req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 chk("t5_no_rsp", rsp_valid, 0);
    end
    set_op(0, 16'h00FF, 16'h0F01, 1'b0);
    req_valid[0] = 1'b1;
    wait_accept(0);
    wait_rsp(s, c, id);
    chk("t5_sum", s, 16'h1000);
    chk("t5_cout", c, 0);
    chk("t5_id", id, 0);

    // Random traffic; a requester only changes its fields when idle or just granted.
    n0 = n_rsp;
    done_ok = 0;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      @(negedge clk);
      granted = req_valid & req_ready;
      if (n_rsp - n0 >= NOPS) begin
        done_ok = 1;
        break;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (granted[i] || !req_valid[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            set_op(i, rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
            req_valid[i] = 1'b1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    chk("random_ops_completed", done_ok, 1);

    @(posedge clk);
    #1 req_valid = '0;
    rsp_ready = 1'b1;
    repeat (NSTEP + 4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
